// File: rtl/crc32_dn_engine.sv
// crc32_dn_engine: Ethernet CRC-32 (reflected 0x04C11DB7) over DATA_W-bit beats
// with an end-beat byte keep mask, a registered FCS and a protocol error pulse.
// Optional macro CRC32_CHECK_EN adds the crc_ok residue-check output.
module crc32_dn_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] data,
  input  logic [KEEP_W-1:0] data_keep,
  input  logic              crc_start,
  input  logic              crc_en,
  input  logic              crc_end,
  output logic [31:0]       crc32,
  output logic              crc32_valid,
`ifdef CRC32_CHECK_EN
  output logic              crc_ok,
`endif
  output logic              frame_err
);

  localparam int unsigned CRC_W   = 32;
  localparam logic [CRC_W-1:0] SEED    = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] POLY_R  = 32'hEDB8_8320;
  localparam logic [CRC_W-1:0] RESIDUE = 32'h2144_DF1C;

  // Reject unsupported beat widths at elaboration.
  if (!((DATA_W == 8) || (DATA_W == 16) || (DATA_W == 32) || (DATA_W == 64)) ||
      (KEEP_W != DATA_W / 8)) begin : g_bad_width
    $error("crc32_dn_engine: DATA_W must be 8, 16, 32 or 64 with KEEP_W = DATA_W/8");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   acc_q, acc_d;
  logic [CRC_W-1:0]   crc32_q, crc32_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [CRC_W-1:0]   chain [KEEP_W+1];
  logic [CRC_W-1:0]   end_crc;
  logic               keep_ok;
  logic               accept;
  logic               finish;

  // One reflected CRC-32 byte step, LSB of the byte first.
  function automatic logic [CRC_W-1:0] byte_step(input logic [CRC_W-1:0] c,
                                                 input logic [7:0]       b);
    logic [CRC_W-1:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY_R) : (r >> 1);
    end
    return r;
  endfunction

  // Unrolled byte steps over lanes 0..KEEP_W-1, seeded on a start beat.
  always_comb begin
    chain[0] = crc_start ? SEED : acc_q;
    for (int i = 0; i < KEEP_W; i++) begin
      chain[i+1] = byte_step(chain[i], data[8*i +: 8]);
    end
  end

  // Keep-mask legality (contiguous from lane 0, non-zero) and lane-count mux.
  always_comb begin
    keep_ok = 1'b0;
    end_crc = chain[KEEP_W];
    for (int n = 1; n <= KEEP_W; n++) begin
      if (data_keep == KEEP_W'((1 << n) - 1)) begin
        keep_ok = 1'b1;
        end_crc = chain[n];
      end
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a restart in RUN stays in RUN unless it is also the end beat.
  always_comb begin
    state_d = state_q;
    if (crc_en) begin
      case (state_q)
        ST_IDLE: if (crc_start && !crc_end) state_d = ST_RUN;
        ST_RUN:  if (crc_end) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    accept  = crc_en && (crc_start || (state_q == ST_RUN));
    finish  = accept && crc_end && keep_ok;
    err_d   = crc_en && ((!crc_start && (state_q == ST_IDLE)) ||
                         (crc_start && (state_q == ST_RUN)) ||
                         (accept && crc_end && !keep_ok));
    valid_d = finish;
    acc_d   = acc_q;
    if (accept) acc_d = crc_end ? SEED : chain[KEEP_W];
    crc32_d = crc32_q;
    if (finish) crc32_d = ~end_crc;
  end

  // Accumulator and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc_q   <= SEED;
      crc32_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      crc32_q <= crc32_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign crc32       = crc32_q;
  assign crc32_valid = valid_q;
  assign frame_err   = err_q;

`ifdef CRC32_CHECK_EN
  logic ok_q, ok_d;

  // Residue compare, captured alongside crc32 and held until the next finish.
  always_comb begin
    ok_d = ok_q;
    if (finish) ok_d = (~end_crc == RESIDUE);
  end

  // crc_ok register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) ok_q <= 1'b0;
    else         ok_q <= ok_d;
  end

  assign crc_ok = ok_q;
`endif

endmodule

// File: tb/tb_crc32_dn_engine.sv
// Bench for crc32_dn_engine: directed vector table plus random beats on a
// DATA_W=32 instance checked against a byte-queue reference model, and the
// byte-serial reference vector on a DATA_W=8 instance.
module tb_crc32_dn_engine;

  localparam bit T = 1'b1;
  localparam bit F = 1'b0;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // DATA_W=32 instance signals
  logic        sys_rst = 1'b1;
  logic [31:0] data = '0;
  logic [3:0]  data_keep = '0;
  logic        crc_start = 1'b0, crc_en = 1'b0, crc_end = 1'b0;
  logic [31:0] crc32;
  logic        crc32_valid, frame_err;
`ifdef CRC32_CHECK_EN
  logic        crc_ok;
`endif

  // DATA_W=8 instance signals
  logic [7:0]  b_data = '0;
  logic [0:0]  b_keep = 1'b1;
  logic        b_start = 1'b0, b_en = 1'b0, b_end = 1'b0;
  logic [31:0] b_crc;
  logic        b_valid, b_err;
`ifdef CRC32_CHECK_EN
  logic        b_ok;
`endif

  crc32_dn_engine #(.DATA_W(32)) u_dut32 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .data(data), .data_keep(data_keep),
    .crc_start(crc_start), .crc_en(crc_en), .crc_end(crc_end),
    .crc32(crc32), .crc32_valid(crc32_valid),
`ifdef CRC32_CHECK_EN
    .crc_ok(crc_ok),
`endif
    .frame_err(frame_err)
  );

  crc32_dn_engine #(.DATA_W(8)) u_dut8 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .data(b_data), .data_keep(b_keep),
    .crc_start(b_start), .crc_en(b_en), .crc_end(b_end),
    .crc32(b_crc), .crc32_valid(b_valid),
`ifdef CRC32_CHECK_EN
    .crc_ok(b_ok),
`endif
    .frame_err(b_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: open-frame flag plus the byte queue of the frame so far.
  bit          m_open = 1'b0;
  logic [7:0]  m_q[$];
  logic [31:0] m_crc = '0;
  bit          m_valid = 1'b0, m_err = 1'b0, m_ok = 1'b0;

  // Bit-serial CRC-32 (reflected) over the whole queued frame.
  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    bit fb;
    c = 32'hFFFF_FFFF;
    foreach (m_q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ m_q[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit st, input bit e,
                            input logic [31:0] d, input logic [3:0] k);
    int n;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_open = 1'b0; m_q.delete(); m_crc = '0; m_ok = 1'b0;
      return;
    end
    if (!en) return;
    if (st) begin
      if (m_open) m_err = 1'b1;
      m_q.delete();
      m_open = 1'b1;
    end else if (!m_open) begin
      m_err = 1'b1;
      return;
    end
    if (e) begin
      n = 0;
      for (int i = 1; i <= 4; i++) if (int'(k) == (1 << i) - 1) n = i;
      m_open = 1'b0;
      if (n == 0) begin
        m_err = 1'b1;
      end else begin
        for (int i = 0; i < n; i++) m_q.push_back(d[8*i +: 8]);
        m_crc   = ref_crc();
        m_valid = 1'b1;
        m_ok    = (m_crc == 32'h2144_DF1C);
      end
    end else begin
      for (int i = 0; i < 4; i++) m_q.push_back(d[8*i +: 8]);
    end
  endtask

  // Drive one beat, advance one cycle, and compare outputs with the model.
  task automatic apply(input bit rst, input bit en, input bit st, input bit e,
                       input logic [31:0] d, input logic [3:0] k);
    sys_rst = rst; crc_en = en; crc_start = st; crc_end = e; data = d; data_keep = k;
    model_step(rst, en, st, e, d, k);
    @(negedge sys_clk);
    chk("model_crc32", crc32, m_crc);
    chk("model_valid", 32'(crc32_valid), 32'(m_valid));
    chk("model_frame_err", 32'(frame_err), 32'(m_err));
`ifdef CRC32_CHECK_EN
    chk("model_crc_ok", 32'(crc_ok), 32'(m_ok));
`endif
  endtask

  typedef struct {
    bit          rst, en, st, e;
    logic [31:0] d;
    logic [3:0]  k;
    bit          xv, xe;
    logic [31:0] xc;
  } vec_t;

  localparam logic [31:0] GOOD = 32'hCBF4_3926;
  localparam logic [31:0] W0 = 32'h3433_3231;
  localparam logic [31:0] W1 = 32'h3837_3635;
  localparam logic [31:0] W2 = 32'h0000_0039;

  vec_t tv[26];
  string s;

  initial begin
    // rst en st e data keep | valid err crc32
    tv[0]  = '{T, F, F, F, 32'h0,         4'h0, F, F, 32'h0};
    tv[1]  = '{F, F, F, F, 32'h0,         4'h0, F, F, 32'h0};
    tv[2]  = '{F, T, F, F, 32'hDEAD_BEEF, 4'hF, F, T, 32'h0};
    tv[3]  = '{F, T, T, F, W0,            4'hF, F, F, 32'h0};
    tv[4]  = '{F, F, F, F, 32'h0,         4'h0, F, F, 32'h0};
    tv[5]  = '{F, T, F, F, W1,            4'hF, F, F, 32'h0};
    tv[6]  = '{F, T, F, T, W2,            4'h1, T, F, GOOD};
    tv[7]  = '{F, T, T, F, W0,            4'hF, F, F, GOOD};
    tv[8]  = '{F, T, F, F, W1,            4'hF, F, F, GOOD};
    tv[9]  = '{F, T, F, T, W2,            4'h5, F, T, GOOD};
    tv[10] = '{F, T, T, F, W0,            4'hF, F, F, GOOD};
    tv[11] = '{F, T, T, F, W0,            4'hF, F, T, GOOD};
    tv[12] = '{F, T, F, F, W1,            4'hF, F, F, GOOD};
    tv[13] = '{F, T, F, T, W2,            4'h1, T, F, GOOD};
    tv[14] = '{F, T, T, F, W0,            4'hF, F, F, GOOD};
    tv[15] = '{F, T, F, F, W1,            4'hF, F, F, GOOD};
    tv[16] = '{F, T, F, T, W2,            4'h1, T, F, GOOD};
    tv[17] = '{F, T, T, F, W0,            4'hF, F, F, GOOD};
    tv[18] = '{F, T, F, F, W1,            4'hF, F, F, GOOD};
    tv[19] = '{T, T, F, T, W2,            4'h1, F, F, 32'h0};
    tv[20] = '{F, T, T, F, W0,            4'hF, F, F, 32'h0};
    tv[21] = '{F, T, F, F, W1,            4'hF, F, F, 32'h0};
    tv[22] = '{F, T, F, T, W2,            4'h1, T, F, GOOD};
    tv[23] = '{F, T, T, F, W0,            4'hF, F, F, GOOD};
    tv[24] = '{F, T, F, T, W1,            4'h0, F, T, GOOD};
    tv[25] = '{F, T, F, F, W1,            4'hF, F, T, GOOD};

    for (int i = 0; i < 26; i++) begin
      apply(tv[i].rst, tv[i].en, tv[i].st, tv[i].e, tv[i].d, tv[i].k);
      chk($sformatf("tv%0d_crc32", i), crc32, tv[i].xc);
      chk($sformatf("tv%0d_valid", i), 32'(crc32_valid), 32'(tv[i].xv));
      chk($sformatf("tv%0d_frame_err", i), 32'(frame_err), 32'(tv[i].xe));
    end
    apply(F, F, F, F, 32'h0, 4'h0);

    // Byte-serial reference vector on the 8-bit instance.
    s = "123456789";
    for (int i = 0; i < 9; i++) begin
      b_en = 1'b1; b_start = (i == 0); b_end = (i == 8); b_data = s[i]; b_keep = 1'b1;
      @(negedge sys_clk);
      chk($sformatf("b8_valid_beat%0d", i), 32'(b_valid), 32'(i == 8));
      chk($sformatf("b8_err_beat%0d", i), 32'(b_err), 32'h0);
    end
    chk("b8_crc32", b_crc, GOOD);
    b_en = 1'b0; b_start = 1'b0; b_end = 1'b0;
    @(negedge sys_clk);
    chk("b8_valid_after", 32'(b_valid), 32'h0);
    chk("b8_crc32_hold", b_crc, GOOD);

`ifdef CRC32_CHECK_EN
    // "123456789" followed by its own FCS bytes 26 39 F4 CB.
    apply(F, T, T, F, W0, 4'hF);
    apply(F, T, F, F, W1, 4'hF);
    apply(F, T, F, F, 32'hF439_2639, 4'hF);
    apply(F, T, F, T, 32'h0000_00CB, 4'h1);
    chk("chk_residue", crc32, 32'h2144_DF1C);
    chk("chk_ok_good", 32'(crc_ok), 32'h1);
    apply(F, T, T, F, 32'h3533_3231, 4'hF);
    apply(F, T, F, F, W1, 4'hF);
    apply(F, T, F, F, 32'hF439_2639, 4'hF);
    apply(F, T, F, T, 32'h0000_00CB, 4'h1);
    chk("chk_ok_bad", 32'(crc_ok), 32'h0);
    apply(F, F, F, F, 32'h0, 4'h0);
    chk("chk_ok_hold", 32'(crc_ok), 32'h0);
`endif

    // Random beats against the byte-queue model.
    for (int i = 0; i < 600; i++) begin
      bit r_rst, r_en, r_st, r_e;
      logic [3:0] r_k;
      r_rst = ($urandom_range(63) == 0);
      r_en  = ($urandom_range(3) != 0);
      r_st  = ($urandom_range(5) == 0);
      r_e   = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) r_k = 4'($urandom);
      else                        r_k = 4'((1 << $urandom_range(4, 1)) - 1);
      apply(r_rst, r_en, r_st, r_e, $urandom, r_k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
